// File: rtl/boot_loader_mem.sv
// boot_loader_mem: word RAM that self-loads a length-prefixed little-endian image from a byte stream, then releases the core.
// Latency: memdout 1 cycle after memaddr; each image word reaches RAM the cycle after its 4th byte. Backpressure: in_ready
// high every cycle while loading, low in RUN/ERR. Define BOOT_CHECKSUM_EN to require a trailing 32-bit word-sum check.
module boot_loader_mem #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              core_rstn,
    input  logic              memwe,
    input  logic [ADDR_W-1:0] memaddr,
    input  logic [31:0]       memdin,
    output logic [31:0]       memdout,
    output logic              load_done,
    output logic              load_err
);

    typedef enum logic [2:0] {
        ST_HDR,
        ST_DATA,
        ST_CSUM,
        ST_RUN,
        ST_ERR
    } state_t;

`ifdef BOOT_CHECKSUM_EN
    localparam state_t LOAD_END = ST_CSUM;
`else
    localparam state_t LOAD_END = ST_RUN;
`endif

    localparam int              PAD  = 32 - ADDR_W;
    localparam logic [ADDR_W-1:0] WONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state;
    state_t            state_n;

    logic [1:0]        bcnt;
    logic [23:0]       asm_q;
    logic [31:0]       full_word;
    logic              accept;
    logic              word_done;

    logic [31:0]       nlen;
    logic [ADDR_W-1:0] wcnt;
    logic              wr_pend;
    logic [31:0]       wr_dat;
    logic              last_word;

    logic [31:0]       mem [DEPTH];

`ifdef BOOT_CHECKSUM_EN
    logic [31:0]       sum;
`endif

    assign in_ready  = !rst && (state == ST_HDR || state == ST_DATA || state == ST_CSUM);
    assign core_rstn = (state == ST_RUN);
    assign load_done = (state == ST_RUN);
    assign load_err  = (state == ST_ERR);

    assign accept    = in_valid && in_ready;
    assign word_done = accept && (bcnt == 2'd3);
    assign full_word = {in_data, asm_q};
    assign last_word = wr_pend && ({{PAD{1'b0}}, wcnt} == (nlen - 32'd1));

    // Byte assembler is shared by header, data and checksum words; bcnt never
    // resets between phases so back-to-back bytes across a phase change stay aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            bcnt  <= 2'd0;
            asm_q <= 24'd0;
        end else if (accept) begin
            bcnt <= bcnt + 2'd1;
            case (bcnt)
                2'd0:    asm_q[7:0]   <= in_data;
                2'd1:    asm_q[15:8]  <= in_data;
                2'd2:    asm_q[23:16] <= in_data;
                default: asm_q        <= asm_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_HDR;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_HDR: begin
                if (word_done) begin
                    if (full_word == 32'd0) begin
                        state_n = LOAD_END;
                    end else if (full_word > 32'(DEPTH)) begin
                        state_n = ST_ERR;
                    end else begin
                        state_n = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (last_word) begin
                    state_n = LOAD_END;
                end
            end
`ifdef BOOT_CHECKSUM_EN
            ST_CSUM: begin
                if (word_done) begin
                    state_n = (full_word == sum) ? ST_RUN : ST_ERR;
                end
            end
`endif
            ST_RUN:  state_n = ST_RUN;
            ST_ERR:  state_n = ST_ERR;
            default: state_n = ST_ERR;
        endcase
    end

    // A completed data word is held one cycle, then written at wcnt.
    always_ff @(posedge clk) begin
        if (rst) begin
            nlen    <= 32'd0;
            wcnt    <= {ADDR_W{1'b0}};
            wr_pend <= 1'b0;
            wr_dat  <= 32'd0;
        end else begin
            wr_pend <= (state == ST_DATA) && word_done;
            if (word_done) begin
                wr_dat <= full_word;
            end
            if (state == ST_HDR && word_done) begin
                nlen <= full_word;
            end
            if (wr_pend) begin
                wcnt <= wcnt + WONE;
            end
        end
    end

`ifdef BOOT_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            sum <= 32'd0;
        end else if (wr_pend) begin
            sum <= sum + wr_dat;
        end
    end
`endif

    // Loader and core never write in the same cycle: loader writes only outside RUN.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (wr_pend) begin
                mem[wcnt] <= wr_dat;
            end else if (state == ST_RUN && memwe) begin
                mem[memaddr] <= memdin;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            memdout <= 32'd0;
        end else begin
            memdout <= mem[memaddr];
        end
    end

endmodule

// File: tb/tb_boot_loader_mem.sv
// Bench for boot_loader_mem: byte-stream image loads, core-port reads checked through an expected-value queue.
module tb_boot_loader_mem;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        core_rstn;
    logic        memwe = 1'b0;
    logic [7:0]  memaddr = 8'd0;
    logic [31:0] memdin = 32'd0;
    logic [31:0] memdout;
    logic        load_done;
    logic        load_err;

    int          n_chk = 0;
    int          n_err = 0;
    logic        rd_en = 1'b0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    boot_loader_mem #(.ADDR_W(8), .DEPTH(256)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .core_rstn (core_rstn),
        .memwe     (memwe),
        .memaddr   (memaddr),
        .memdin    (memdin),
        .memdout   (memdout),
        .load_done (load_done),
        .load_err  (load_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Read results appear one edge after the address is sampled.
    always @(posedge clk) begin
        if (rd_en) begin
            #1;
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                chk(tag_q.pop_front(), memdout, exp_q.pop_front());
            end
        end
    end

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        memwe    = 1'b0;
        rd_en    = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_core_rstn", core_rstn, 1'b0);
        chk("rst_load_done", load_done, 1'b0);
        chk("rst_load_err", load_err, 1'b0);
        chk("rst_memdout", memdout, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1'b1);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        waited   = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) chk("rdy_timeout", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8], gap);
        end
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] e, input string tag);
        memaddr = a;
        rd_en   = 1'b1;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        memaddr = a;
        memdin  = d;
        memwe   = 1'b1;
        @(negedge clk);
        memwe = 1'b0;
    endtask

    task automatic finish_load(input logic [31:0] s);
`ifdef BOOT_CHECKSUM_EN
        send_word(s, 0);
`else
        if (s === 32'hxxxxxxxx) n_err = n_err;
`endif
        @(negedge clk);
        chk("ld_done", load_done, 1'b1);
        chk("ld_err", load_err, 1'b0);
        chk("ld_rstn", core_rstn, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] s;
        int          bad;
        logic [7:0]  part [6];

        @(negedge clk);

        // 1) two-word image at full rate
        do_reset();
        send_word(32'd2, 0);
        send_word(32'h00A00513, 0);
        send_word(32'h00100093, 0);
`ifdef BOOT_CHECKSUM_EN
        chk("t1_rstn_before_csum", core_rstn, 1'b0);
        send_word(32'h00B005A6, 0);
        chk("t1_rstn_after_csum", core_rstn, 1'b1);
`else
        chk("t1_rstn_hold", core_rstn, 1'b0);
        @(negedge clk);
        chk("t1_rstn_rise", core_rstn, 1'b1);
`endif
        chk("t1_load_done", load_done, 1'b1);
        chk("t1_in_ready", in_ready, 1'b0);
        rd(8'd0, 32'h00A00513, "t1_ram0");
        rd(8'd1, 32'h00100093, "t1_ram1");

        // 4) core port in RUN, including read-during-write
        wr(8'd5, 32'hDEADBEEF);
        rd(8'd5, 32'hDEADBEEF, "t4_rd5");
        memaddr = 8'd5;
        memdin  = 32'h12345678;
        memwe   = 1'b1;
        rd_en   = 1'b1;
        exp_q.push_back(32'hDEADBEEF);
        tag_q.push_back("t4_rdw_old");
        @(negedge clk);
        memwe = 1'b0;
        rd_en = 1'b0;
        rd(8'd5, 32'h12345678, "t4_rd5_new");

        // 2) empty image
        do_reset();
        send_word(32'd0, 0);
`ifdef BOOT_CHECKSUM_EN
        chk("t2_rstn_csum_wait", core_rstn, 1'b0);
        send_word(32'd0, 0);
`endif
        chk("t2_rstn", core_rstn, 1'b1);
        chk("t2_load_done", load_done, 1'b1);
        rd(8'd0, 32'h00A00513, "t2_ram0");
        rd(8'd1, 32'h00100093, "t2_ram1");
        rd(8'd5, 32'h12345678, "t2_ram5");

        // 3) oversize image rejected
        do_reset();
        send_word(32'd257, 0);
        chk("t3_load_err", load_err, 1'b1);
        chk("t3_in_ready", in_ready, 1'b0);
        chk("t3_load_done", load_done, 1'b0);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (core_rstn !== 1'b0 || load_err !== 1'b1) bad++;
            @(negedge clk);
        end
        chk("t3_held_cycles", bad, 0);
        wr(8'd0, 32'hFFFFFFFF);
        rd(8'd0, 32'h00A00513, "t3_memwe_ignored");

        // full-depth image
        do_reset();
        send_word(32'd256, 0);
        s = 32'd0;
        for (int i = 0; i < 256; i++) begin
            send_word(32'hA5000000 | i, 0);
            s = s + (32'hA5000000 | i);
        end
        finish_load(s);
        rd(8'd0, 32'hA5000000, "tmax_ram0");
        rd(8'd255, 32'hA50000FF, "tmax_ram255");

        // 5) gappy partial load, reset, then clean reload
        do_reset();
        part = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22};
        for (int i = 0; i < 6; i++) begin
            send_byte(part[i], (i % 3) + 1);
        end
        do_reset();
        send_word(32'd1, 0);
        send_word(32'hCAFEF00D, 0);
        finish_load(32'hCAFEF00D);
        rd(8'd0, 32'hCAFEF00D, "t5_ram0");
        rd(8'd1, 32'hA5000001, "t5_ram1");

`ifdef BOOT_CHECKSUM_EN
        // 6) checksum accept and reject
        do_reset();
        send_word(32'd2, 0);
        send_word(32'd1, 0);
        send_word(32'd2, 0);
        send_word(32'd3, 0);
        @(negedge clk);
        chk("t6_good_done", load_done, 1'b1);
        do_reset();
        send_word(32'd2, 0);
        send_word(32'd1, 0);
        send_word(32'd2, 0);
        send_word(32'd4, 0);
        @(negedge clk);
        chk("t6_bad_err", load_err, 1'b1);
        chk("t6_bad_rstn", core_rstn, 1'b0);
`endif

        repeat (3) @(negedge clk);
        chk("sb_drain", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
